// File: rtl/fifo_rd_pkg.sv
// Shared helpers for the FIFO read-side serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_OUT_WIDTH  = 16;

    // Counter width for n states; a single state still gets one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Number of output slices per FIFO word.
    function automatic int ratio_of(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

endpackage

// File: rtl/fifo_rd_slot.sv
// Single-word register with a valid flag; load wins over clear.
// Latency: one cycle from load_i to dat_o/vld_o.
// Backpressure: none; the owner decides when to load or clear.
module fifo_rd_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] dat_o,
    output logic         vld_o
);

    logic [W-1:0] dat_q;
    logic         vld_q;

    // Capture a new word on load; drop the valid flag on clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else if (load_i) begin
            dat_q <= dat_i;
            vld_q <= 1'b1;
        end else if (clear_i) begin
            vld_q <= 1'b0;
        end
    end

    assign dat_o = dat_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops a synchronous FIFO and emits each word as DATA_WIDTH/OUT_WIDTH slices (optional counters: FIFO_RD_SERIALIZER_CNT_EN).
// Latency: pop in cycle t gives out_valid in cycle t+2; one slice per cycle when streaming.
// Backpressure: out_ready low freezes the slice; at most one word is prefetched, then popping stops.
module fifo_rd_serializer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
`ifdef FIFO_RD_SERIALIZER_CNT_EN
    output logic [31:0]           rd_word_cnt,
    output logic [31:0]           rd_stall_cnt,
`endif
    output logic                  busy
);

    localparam int RATIO = ratio_of(DATA_WIDTH, OUT_WIDTH);
    localparam int IDX_W = clog2_min1(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_bad_width
            $error("fifo_rd_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    logic                  pend_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;

    logic                  shift_vld;
    logic [DATA_WIDTH-1:0] shift_dat;
    logic                  shift_load;
    logic                  shift_clear;
    logic [DATA_WIDTH-1:0] shift_din;

    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic                  hold_load;
    logic                  hold_clear;

    logic                  accept;
    logic                  last_acc;
    logic                  cap_to_shift;
    logic [IDX_W-1:0]      sel;

    // Pop, capture routing and slot control, all from registered state.
    always_comb begin
        fifo_pop     = !reset && !fifo_empty && !pend_q && !hold_vld;
        accept       = shift_vld && out_ready;
        last_acc     = accept && (idx_q == LAST_IDX);
        // A returning word goes straight to shift when shift is free or is being vacated with nothing held.
        cap_to_shift = pend_q && (!shift_vld || (last_acc && !hold_vld));
        hold_load    = pend_q && !cap_to_shift;
        hold_clear   = last_acc && hold_vld;
        shift_load   = cap_to_shift || (last_acc && hold_vld);
        shift_din    = (last_acc && hold_vld) ? hold_dat : fifo_data;
        shift_clear  = last_acc && !shift_load;
        idx_d        = idx_q;
        if (accept) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Track the in-flight pop and the slice index.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            pend_q <= fifo_pop;
            idx_q  <= idx_d;
        end
    end

    fifo_rd_slot #(.W(DATA_WIDTH)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (shift_load),
        .clear_i (shift_clear),
        .dat_i   (shift_din),
        .dat_o   (shift_dat),
        .vld_o   (shift_vld)
    );

    fifo_rd_slot #(.W(DATA_WIDTH)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .dat_i   (fifo_data),
        .dat_o   (hold_dat),
        .vld_o   (hold_vld)
    );

    // Pick the current slice; MSB_FIRST walks the word from the top down.
    always_comb begin
        sel      = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (sel == IDX_W'(i)) begin
                out_data = shift_dat[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign out_valid = shift_vld;
    assign out_last  = shift_vld && (idx_q == LAST_IDX);
    assign busy      = shift_vld || hold_vld || pend_q;

`ifdef FIFO_RD_SERIALIZER_CNT_EN
    logic [31:0] rd_word_cnt_q;
    logic [31:0] rd_stall_cnt_q;

    // Words completed (wrapping) and stalled cycles (saturating).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word_cnt_q  <= '0;
            rd_stall_cnt_q <= '0;
        end else begin
            if (last_acc) begin
                rd_word_cnt_q <= rd_word_cnt_q + 32'd1;
            end
            if (shift_vld && !out_ready && rd_stall_cnt_q != 32'hFFFF_FFFF) begin
                rd_stall_cnt_q <= rd_stall_cnt_q + 32'd1;
            end
        end
    end

    assign rd_word_cnt  = rd_word_cnt_q;
    assign rd_stall_cnt = rd_stall_cnt_q;
`endif

endmodule
